// File: rtl/palram_arbiter.sv
// -----------------------------------------------------------------------------
// palram_arbiter
// Shares the single-port palette RAM between the GA25 pixel lookup and the
// main CPU. Pixel lookups own every active-video ce_pix cycle. The CPU uses
// every other cycle through a one-entry posted write buffer and a stalled
// read path.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   ce_pix            pixel clock enable
//   video_active      1 = pixel lookup needed on this ce_pix (not blanking)
//   pix_addr          colour index from GA25
//   pix_color         registered palette colour (black during blanking)
//   cpu_cs/rd/wr      CPU palette select and level read/write strobes
//   cpu_addr/din      CPU word address / write data
//   cpu_dout          registered CPU read data
//   cpu_busy          CPU must hold its request while high
//   ram_addr/wren/data  palette RAM address, write enable, write data
//   ram_q             palette RAM read data (one clock registered latency)
// -----------------------------------------------------------------------------
module palram_arbiter #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          video_active,
    input  logic [AW-1:0] pix_addr,
    output logic [DW-1:0] pix_color,
    input  logic          cpu_cs,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wren,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state_r;
    logic          rd_inflight_r;   // read address went to the RAM last cycle
    logic [AW-1:0] rd_addr_r;       // address of the read being served
    logic          wb_full_r;
    logic [AW-1:0] wb_addr_r;
    logic [DW-1:0] wb_data_r;
    logic          pix_pend_r;
    logic          blank_pend_r;

    logic pix_slot_s;
    logic free_s;
    logic drain_s;
    logic rd_req_s;
    logic wr_req_s;
    logic wr_hit_s;
    logic fwd_s;
    logic rd_issue_s;
    logic wr_accept_s;
    logic rd_done_hit_s;

    // Slot classification and CPU request decode.
    // free_s is gated by reset so a buffered write cannot reach the RAM in
    // the cycle that discards it.
    always_comb begin
        pix_slot_s    = ce_pix & video_active;
        free_s        = ~pix_slot_s & ~reset;
        drain_s       = free_s & wb_full_r;
        rd_req_s      = cpu_cs & cpu_rd & ~cpu_wr;   // read+write counts as a write
        wr_req_s      = cpu_cs & cpu_wr;
        wr_hit_s      = (cpu_addr == wb_addr_r);
        fwd_s         = (state_r == ST_IDLE) & rd_req_s & wb_full_r & wr_hit_s;
        // A read only reaches the RAM once the buffer is empty, so it always
        // sees the most recent CPU write.
        rd_issue_s    = free_s & ~wb_full_r & rd_req_s &
                        (((state_r == ST_IDLE) & ~fwd_s) |
                         ((state_r == ST_ISSUE) & ~rd_inflight_r));
        // A different-address write can take the buffer in the cycle the old
        // entry drains, so busy never lasts beyond one drain.
        wr_accept_s   = wr_req_s & (~wb_full_r | wr_hit_s | drain_s);
        // DONE only satisfies a read that is still aimed at the served address;
        // a new address must not see stale data for even one cycle.
        rd_done_hit_s = (state_r == ST_DONE) & (cpu_addr == rd_addr_r);
    end

    // CPU stall: pending read not yet served, or write blocked by a full buffer.
    always_comb begin
        cpu_busy = (rd_req_s & ~rd_done_hit_s) | (wr_req_s & ~wr_accept_s);
    end

    // Palette RAM port mux: pixel, then buffer drain, then CPU read.
    always_comb begin
        ram_addr = pix_addr;
        ram_wren = 1'b0;
        ram_data = wb_data_r;
        if (pix_slot_s) begin
            ram_addr = pix_addr;
            ram_wren = 1'b0;
        end else if (drain_s) begin
            ram_addr = wb_addr_r;
            ram_wren = 1'b1;
        end else if (rd_issue_s) begin
            ram_addr = cpu_addr;
            ram_wren = 1'b0;
        end else begin
            ram_addr = pix_addr;
            ram_wren = 1'b0;
        end
    end

    // One-entry posted write buffer with same-address coalescing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_full_r <= 1'b0;
            wb_addr_r <= '0;
            wb_data_r <= '0;
        end else if (wr_accept_s) begin
            wb_full_r <= 1'b1;
            wb_addr_r <= cpu_addr;
            wb_data_r <= cpu_din;
        end else if (drain_s) begin
            wb_full_r <= 1'b0;
        end
    end

    // CPU read FSM: forward from the buffer, or issue to RAM and capture ram_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rd_inflight_r <= 1'b0;
            rd_addr_r     <= '0;
            cpu_dout      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fwd_s) begin
                        cpu_dout  <= wb_data_r;
                        rd_addr_r <= cpu_addr;
                        state_r   <= ST_DONE;
                    end else if (rd_req_s) begin
                        rd_addr_r     <= cpu_addr;
                        rd_inflight_r <= rd_issue_s;
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rd_inflight_r) begin
                        cpu_dout      <= ram_q;
                        rd_inflight_r <= 1'b0;
                        state_r       <= ST_DONE;
                    end else if (rd_issue_s) begin
                        rd_inflight_r <= 1'b1;
                    end else if (!rd_req_s) begin
                        // Requester gave up before the read went out.
                        state_r <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    // Keep the held read data coherent with a CPU write to it.
                    if (wr_accept_s && (cpu_addr == rd_addr_r)) begin
                        cpu_dout <= cpu_din;
                    end
                    if (!cpu_cs || !cpu_rd || (cpu_addr != rd_addr_r)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    rd_inflight_r <= 1'b0;
                end
            endcase
        end
    end

    // Pixel colour register: RAM data the cycle after a lookup, black in blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_pend_r   <= 1'b0;
            blank_pend_r <= 1'b0;
            pix_color    <= '0;
        end else begin
            pix_pend_r   <= pix_slot_s;
            blank_pend_r <= ce_pix & ~video_active;
            if (pix_pend_r) begin
                pix_color <= ram_q;
            end else if (blank_pend_r) begin
                pix_color <= '0;
            end
        end
    end

endmodule

// File: tb/tb_palram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_palram_arbiter
// Directed stimulus with a scoreboard: expected RAM writes, CPU read data and
// pixel colours are queued as stimulus is issued; monitors pop and compare
// whenever the DUT presents the corresponding output.
// -----------------------------------------------------------------------------
module tb_palram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic        video_active;
    logic [10:0] pix_addr;
    logic [15:0] pix_color;
    logic        cpu_cs;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_busy;
    logic [10:0] ram_addr;
    logic        ram_wren;
    logic [15:0] ram_data;
    logic [15:0] ram_q;

    typedef struct { logic [10:0] a; logic [15:0] d; } wr_t;
    typedef struct { int due; logic [15:0] v; } pix_t;

    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    pix_t        pix_q[$];
    logic [15:0] exp_pix;

    int n_checks = 0;
    int n_pass   = 0;

    palram_arbiter #(.AW(11), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .ce_pix(ce_pix), .video_active(video_active),
        .pix_addr(pix_addr), .pix_color(pix_color),
        .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
        .ram_addr(ram_addr), .ram_wren(ram_wren),
        .ram_data(ram_data), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Palette RAM model: contents start at 0xA000|addr with two known entries.
    logic [15:0] mem [0:2047];
    bit          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'hA000 | 16'(i);
            mem[11'h123] <= 16'h7C1F;
            mem[11'h300] <= 16'h2468;
            ram_ready    <= 1'b1;
            ram_q        <= 16'h0000;
        end else begin
            if (ram_wren) mem[ram_addr] <= ram_data;
            ram_q <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM write monitor: every write strobe must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (ram_wren === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_ram_write_addr", ram_addr, 11'h7FF);
                end else begin
                    e = wr_q.pop_front();
                    check("ram_write_addr", ram_addr, e.a);
                    check("ram_write_data", ram_data, e.d);
                end
            end
        end
    end

    // CPU read monitor: first non-busy cycle of each read presents cpu_dout.
    initial begin
        bit taken = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                taken = 1'b0;
            end else if (cpu_cs && cpu_rd && !cpu_wr && !cpu_busy) begin
                if (!taken) begin
                    taken = 1'b1;
                    if (rd_q.size() == 0) check("unexpected_read_done", cpu_dout, 16'hDEAD);
                    else check("cpu_dout", cpu_dout, rd_q.pop_front());
                end
            end else if (!(cpu_cs && cpu_rd)) begin
                taken = 1'b0;
            end
        end
    end

    // Pixel monitor: colour appears two cycles after the ce_pix cycle
    // (RAM latency plus the colour register); PIX slots must never write.
    initial begin
        int   cyc = 0;
        pix_t p;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pix_q.delete();
            end else begin
                if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
                    p = pix_q.pop_front();
                    check("pix_color", pix_color, p.v);
                end
                if (ce_pix) begin
                    p.due = cyc + 2;
                    p.v   = video_active ? exp_pix : 16'h0000;
                    pix_q.push_back(p);
                end
                if (ce_pix && video_active) begin
                    check("pix_slot_wren", ram_wren, 1'b0);
                    check("pix_slot_addr", ram_addr, pix_addr);
                end
            end
        end
    end

    task automatic do_read(input logic [10:0] a, input logic [15:0] exp,
                           input logic pix_first, output int busy_n);
        cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
        rd_q.push_back(exp);
        ce_pix = pix_first; video_active = 1'b1;
        busy_n = 0;
        while (busy_n < 20) begin
            @(negedge clk);
            if (!cpu_busy) break;
            busy_n++;
            tick();
            ce_pix = 1'b0;
        end
        check("read_timeout", (busy_n < 20), 1'b1);
        tick();
        ce_pix = 1'b0;
    endtask

    initial begin
        int n;
        wr_t w;
        reset = 1'b1; ce_pix = 1'b0; video_active = 1'b0; pix_addr = 11'h123;
        cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 11'h000; cpu_din = 16'h0000;
        exp_pix = 16'h7C1F;
        tick(); tick();
        @(negedge clk);
        check("reset_pix_color", pix_color, 16'h0000);
        check("reset_cpu_dout", cpu_dout, 16'h0000);
        check("reset_ram_wren", ram_wren, 1'b0);
        check("reset_cpu_busy", cpu_busy, 1'b0);
        tick();
        reset = 1'b0;

        // Pixel lookups every 3 clk, one blanking pulse, then active again.
        for (int k = 0; k < 4; k++) begin
            ce_pix = 1'b1; video_active = 1'b1; tick();
            ce_pix = 1'b0; tick(); tick();
        end
        ce_pix = 1'b1; video_active = 1'b0; tick();
        ce_pix = 1'b0; video_active = 1'b1; tick(); tick();
        ce_pix = 1'b1; tick();
        ce_pix = 1'b0; tick(); tick();

        // Posted write, drained on the next free clk.
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h010; cpu_din = 16'h05A5;
        w.a = 11'h010; w.d = 16'h05A5; wr_q.push_back(w);
        @(negedge clk); check("wr_capture_busy", cpu_busy, 1'b0);
        tick();
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        @(negedge clk); check("wr_drain_next_clk", ram_wren, 1'b1);
        tick(); tick();

        // Buffer full across a PIX slot, then a different-address write.
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h010; cpu_din = 16'h0A0A;
        w.a = 11'h010; w.d = 16'h0A0A; wr_q.push_back(w);
        @(negedge clk); check("wr2_capture_busy", cpu_busy, 1'b0);
        tick();
        ce_pix = 1'b1; video_active = 1'b1; cpu_addr = 11'h011; cpu_din = 16'h1111;
        w.a = 11'h011; w.d = 16'h1111; wr_q.push_back(w);
        @(negedge clk); check("wr_blocked_in_pix", cpu_busy, 1'b1);
        tick();
        ce_pix = 1'b0;
        @(negedge clk);
        check("wr_accept_on_drain", cpu_busy, 1'b0);
        check("drain_addr_first", ram_addr, 11'h010);
        tick();
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        @(negedge clk); check("drain_second_wren", ram_wren, 1'b1);
        tick(); tick();

        // Read forwarded from the write buffer (RAM still holds 0xA020).
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h020; cpu_din = 16'h4321;
        w.a = 11'h020; w.d = 16'h4321; wr_q.push_back(w);
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b1; ce_pix = 1'b1; video_active = 1'b1;
        rd_q.push_back(16'h4321);
        @(negedge clk); check("fwd_request_busy", cpu_busy, 1'b1);
        tick();
        ce_pix = 1'b0;
        @(negedge clk); check("fwd_done_busy", cpu_busy, 1'b0);
        tick();
        @(negedge clk); check("fwd_no_ram_read", ram_addr, 11'h123);
        tick();
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        tick();

        // Best-case read.
        do_read(11'h055, 16'hA055, 1'b0, n);
        check("read_best_latency", n, 2);
        cpu_cs = 1'b0; cpu_rd = 1'b0; tick();

        // Read starting on a PIX slot; worst case is bounded by 4 clk.
        do_read(11'h300, 16'h2468, 1'b1, n);
        check("read_pix_latency_bound", (n >= 2 && n <= 4), 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("read_hold_busy", cpu_busy, 1'b0);
            check("read_hold_dout", cpu_dout, 16'h2468);
            tick();
        end
        // CPU write to the held read address updates cpu_dout.
        cpu_wr = 1'b1; cpu_din = 16'h1357;
        w.a = 11'h300; w.d = 16'h1357; wr_q.push_back(w);
        @(negedge clk); check("done_write_busy", cpu_busy, 1'b0);
        tick();
        cpu_wr = 1'b0;
        @(negedge clk);
        check("done_write_dout", cpu_dout, 16'h1357);
        check("done_write_hold_busy", cpu_busy, 1'b0);
        tick();
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        tick(); tick();
        do_read(11'h300, 16'h1357, 1'b0, n);
        check("read_rearm_latency", n, 2);
        cpu_cs = 1'b0; cpu_rd = 1'b0; tick();

        // Reset with a buffered write pending and the read FSM waiting.
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h040; cpu_din = 16'h0BAD;
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 11'h041; ce_pix = 1'b1; video_active = 1'b1;
        @(negedge clk); check("pre_reset_busy", cpu_busy, 1'b1);
        tick();
        ce_pix = 1'b0; reset = 1'b1; cpu_cs = 1'b0; cpu_rd = 1'b0;
        @(negedge clk); check("reset_cycle_no_drain", ram_wren, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", cpu_busy, 1'b0);
        check("post_reset_wren", ram_wren, 1'b0);
        check("post_reset_dout", cpu_dout, 16'h0000);
        tick(); tick();
        do_read(11'h040, 16'hA040, 1'b0, n);
        check("read_after_reset_latency", n, 2);
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        tick(); tick(); tick();

        check("wr_queue_drained", wr_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        check("pix_queue_drained", pix_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
